// File: rtl/fwd_sel_ctrl_pkg.sv
// Shared definitions for the EX operand-forwarding and load-use stall control.
package fwd_sel_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  // Operand mux select codes (code 2'b11 is reserved and never driven)
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Shadow pipeline stage information
  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{valid: 1'b0, rd: {REG_AW_DEF{1'b0}},
                                      regwrite: 1'b0, memread: 1'b0};

  // True when a used, non-zero source register is produced by the given stage
  function automatic logic src_hits(input logic use_src,
                                    input logic [REG_AW_DEF-1:0] src,
                                    input stage_t stg);
    return use_src && stg.valid && stg.regwrite &&
           (stg.rd != {REG_AW_DEF{1'b0}}) && (src == stg.rd);
  endfunction

endpackage

// File: rtl/fwd_sel_ctrl_src_cmp.sv
// Per-operand source comparator: picks the youngest in-flight producer.
module fwd_src_cmp
  import fwd_sel_ctrl_pkg::*;
(
  input  logic                  i_use,
  input  logic [REG_AW_DEF-1:0] i_src,
  input  stage_t                i_ex,
  input  stage_t                i_mem,
  output logic [1:0]            o_sel
);

  // memread is irrelevant to forwarding; folded here so it is consumed
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, i_ex.memread, i_mem.memread};

  // Priority select: EX producer (MEM next cycle) beats MEM producer (WB next cycle)
  always_comb begin
    o_sel = FWD_RF;
    if (src_hits(i_use, i_src, i_ex)) begin
      o_sel = FWD_MEM;
    end else if (src_hits(i_use, i_src, i_mem)) begin
      o_sel = FWD_WB;
    end else begin
      o_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/fwd_sel_ctrl.sv
// Forwarding select and load-use stall generator sitting beside the ID/EX register.
// Tracks EX/MEM/WB destination info in a shadow pipeline; sel outputs are
// registered so they line up with the instruction's EX cycle.
module fwd_sel_ctrl
  import fwd_sel_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_t           r_ex;
  stage_t           r_mem;
  stage_t           r_wb;
  logic [1:0]       r_fwd_a_sel;
  logic [1:0]       r_fwd_b_sel;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_stall;
  logic             w_bubble;
  logic [1:0]       w_sel_a;
  logic [1:0]       w_sel_b;
  stage_t           w_id_entry;

  // WB info and MEM memread are tracked for completeness but not compared
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, r_wb, r_mem.memread};

  fwd_src_cmp u_cmp_rs (
    .i_use (id_use_rs),
    .i_src (id_rs),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .o_sel (w_sel_a)
  );

  fwd_src_cmp u_cmp_rt (
    .i_use (id_use_rt),
    .i_src (id_rt),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .o_sel (w_sel_b)
  );

  // Load-use detection and selection of the entry that moves into EX
  always_comb begin
    w_stall    = 1'b0;
    w_bubble   = 1'b1;
    w_id_entry = STAGE_BUBBLE;
    if (flush) begin
      w_stall = 1'b0;
    end else begin
      w_stall = id_valid && r_ex.memread &&
                (src_hits(id_use_rs, id_rs, r_ex) || src_hits(id_use_rt, id_rt, r_ex));
    end
    w_bubble = flush || w_stall || !id_valid;
    if (w_bubble) begin
      w_id_entry = STAGE_BUBBLE;
    end else begin
      w_id_entry = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
    end
  end

  // Shadow pipeline advance, registered selects and saturating stall counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ex        <= STAGE_BUBBLE;
      r_mem       <= STAGE_BUBBLE;
      r_wb        <= STAGE_BUBBLE;
      r_fwd_a_sel <= FWD_RF;
      r_fwd_b_sel <= FWD_RF;
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (!hold) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_id_entry;
      if (w_bubble) begin
        r_fwd_a_sel <= FWD_RF;
        r_fwd_b_sel <= FWD_RF;
      end else begin
        r_fwd_a_sel <= w_sel_a;
        r_fwd_b_sel <= w_sel_b;
      end
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign fwd_a_sel = r_fwd_a_sel;
  assign fwd_b_sel = r_fwd_b_sel;
  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Scoreboard bench for fwd_sel_ctrl: directed instruction sequence, expected
// outputs queued per cycle, monitor compares on the falling clock edge.
module tb_fwd_sel_ctrl;

  logic        clk;
  logic        rstn;
  logic        hold;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        stall;
  logic [31:0] stall_cnt;

  logic [36:0] exp_q[$];
  string       name_q[$];
  int          n_cmp;
  int          n_fail;

  fwd_sel_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .hold        (hold),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [36:0] act, input logic [36:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got a=%b b=%b stall=%b cnt=%0d, want a=%b b=%b stall=%b cnt=%0d",
               nm, act[36:35], act[34:33], act[32], act[31:0],
               exp[36:35], exp[34:33], exp[32], exp[31:0]);
    end
  endtask

  // Monitor: pop and compare one expected record per falling edge
  always @(negedge clk) begin : mon
    logic [36:0] e;
    string       nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, {fwd_a_sel, fwd_b_sel, stall, stall_cnt}, e);
    end
  end

  task automatic step(input logic v, input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic fl, input logic hd,
                      input logic [1:0] ea, input logic [1:0] eb, input logic es,
                      input logic [31:0] ec, input string nm);
    @(posedge clk);
    #1;
    id_valid = v;  id_rs = rs;  id_use_rs = urs;  id_rt = rt;  id_use_rt = urt;
    id_rd = rd;    id_regwrite = rw;  id_memread = mr;  flush = fl;  hold = hd;
    exp_q.push_back({ea, eb, es, ec});
    name_q.push_back(nm);
  endtask

  task automatic idle(input logic [1:0] ea, input logic [1:0] eb, input logic [31:0] ec,
                      input string nm);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, 1'b0, ec, nm);
  endtask

  initial begin
    n_cmp = 0;  n_fail = 0;
    rstn = 1'b0;  hold = 1'b0;  flush = 1'b0;  id_valid = 1'b0;
    id_rs = 5'd0;  id_rt = 5'd0;  id_use_rs = 1'b0;  id_use_rt = 1'b0;
    id_rd = 5'd0;  id_regwrite = 1'b0;  id_memread = 1'b0;
    #12 rstn = 1'b1;

    idle(2'b00, 2'b00, 32'd0, "rst_state");
    // ALU back-to-back: add r3 then sub rs=r3
    step(1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0, "add_r3");
    step(1'b1, 5'd3,  1'b1, 5'd6,  1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0, "sub_issue");
    idle(2'b10, 2'b00, 32'd0, "alu_b2b_sel");
    // Distance 2: r5, unrelated, consumer rt=r5
    step(1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0, "prod_r5");
    step(1'b1, 5'd9,  1'b1, 5'd10, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0, "unrel1");
    step(1'b1, 5'd11, 1'b1, 5'd5,  1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0, "cons_d2");
    idle(2'b00, 2'b01, 32'd0, "dist2_sel");
    // Distance 3: register file supplies the value
    step(1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0, "prod_r5b");
    step(1'b1, 5'd9,  1'b1, 5'd10, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0, "unrel2");
    step(1'b1, 5'd9,  1'b1, 5'd10, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0, "unrel3");
    step(1'b1, 5'd11, 1'b1, 5'd5,  1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0, "cons_d3");
    idle(2'b00, 2'b00, 32'd0, "dist3_sel");
    // Load-use: lw r4 then add rs=r4
    step(1'b1, 5'd1,  1'b1, 5'd0,  1'b0, 5'd4,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0, "lw_r4");
    step(1'b1, 5'd4,  1'b1, 5'd6,  1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 32'd0, "lu_stall");
    step(1'b1, 5'd4,  1'b1, 5'd6,  1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd1, "lu_bubble");
    idle(2'b01, 2'b00, 32'd1, "lu_fwd");
    // Register 0 and unused source (ex holds a load of r7, rt=r7 unused)
    step(1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd1, "prod_r0");
    step(1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd1, "cons_r0");
    step(1'b1, 5'd1,  1'b1, 5'd7,  1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd1, "reg0_sel");
    idle(2'b00, 2'b00, 32'd1, "unused_rt_sel");
    // Flush during a load-use condition
    step(1'b1, 5'd1,  1'b1, 5'd0,  1'b0, 5'd4,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd1, "lw_r4b");
    step(1'b1, 5'd4,  1'b1, 5'd6,  1'b1, 5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'd1, "flush_nostall");
    idle(2'b00, 2'b00, 32'd1, "flush_sels");
    // Hold for three cycles with a pending load-use stall
    step(1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd1, "prod_r3");
    step(1'b1, 5'd3,  1'b1, 5'd0,  1'b0, 5'd4,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd1, "lw_r4c");
    step(1'b1, 5'd4,  1'b1, 5'd6,  1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 32'd1, "hold0");
    step(1'b1, 5'd4,  1'b1, 5'd6,  1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 32'd1, "hold1");
    step(1'b1, 5'd4,  1'b1, 5'd6,  1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 32'd1, "hold2");
    step(1'b1, 5'd4,  1'b1, 5'd6,  1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 32'd1, "hold_release");
    step(1'b1, 5'd4,  1'b1, 5'd6,  1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd2, "lu2_bubble");
    step(1'b1, 5'd7,  1'b1, 5'd0,  1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 32'd2, "lu2_fwd");

    // Asynchronous reset in the middle of a load-use stall
    @(posedge clk);
    #1;
    id_valid = 1'b1;  id_rs = 5'd5;  id_use_rs = 1'b1;  id_rt = 5'd6;  id_use_rt = 1'b1;
    id_rd = 5'd8;  id_regwrite = 1'b1;  id_memread = 1'b0;  flush = 1'b0;  hold = 1'b0;
    #1;
    check("pre_rst_stall", {fwd_a_sel, fwd_b_sel, stall, stall_cnt}, {2'b10, 2'b00, 1'b1, 32'd2});
    rstn = 1'b0;
    exp_q.push_back({2'b00, 2'b00, 1'b0, 32'd0});
    name_q.push_back("rst_async");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.push_back({2'b00, 2'b00, 1'b0, 32'd0});
    name_q.push_back("post_rst");
    idle(2'b00, 2'b00, 32'd0, "post_rst2");

    // Drain: every queued expectation must have been consumed
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_sel_ctrl.md
Name: fwd_sel_ctrl

Overview:
- Generates the 2-bit select codes that drive the two 4-way operand muxes in EX.
- Also generates the load-use stall request.
- Keeps an internal shadow pipeline of destination-register and write-enable information for the EX, MEM and WB stages, and compares each ID-stage instruction's sources against it.
- Sits beside the ID/EX pipeline register. Its outputs are registered, so they are valid in the same cycle the instruction occupies EX.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, stall performance counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  reset: asynchronous assert, active-low.
- hold  input  1  global freeze (e.g. memory wait); all state holds.
- flush  input  1  squash the instruction leaving ID (branch taken in EX).
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_AW  source A register.
- id_rt  input  REG_AW  source B register.
- id_use_rs  input  1  instruction reads rs.
- id_use_rt  input  1  instruction reads rt.
- id_rd  input  REG_AW  destination register.
- id_regwrite  input  1  instruction writes rd.
- id_memread  input  1  instruction is a load.
- fwd_a_sel  output  2  EX operand A mux select.
- fwd_b_sel  output  2  EX operand B mux select.
- stall  output  1  freeze PC/IF/ID, insert bubble into EX.
- stall_cnt  output  CNT_W  count of load-use stall cycles.

Behaviour:
- Select encoding (4-way mux: code 11 picks input A … code 00 picks input D):
  - 00 = register-file value (D).
  - 01 = WB-stage result (C).
  - 10 = MEM-stage result (B).
  - 11 = reserved; never driven.
- Shadow stages: ex_*, mem_*, wb_*. Each stage holds {valid, rd, regwrite, memread}.
  - Each clk with hold=0: wb<=mem, mem<=ex, and ex<=ID entry or bubble.
  - A bubble has valid=0 and all fields 0.
- Load-use stall (combinational):
  - stall=1 iff id_valid & ex_valid & ex_memread & ex_regwrite & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
  - stall is forced 0 when flush=1.
  - During a stall, ex receives a bubble and ID is presented again next cycle.
- Select computation, per operand, for the entry moving into ex:
  - If the source equals ex_rd, with ex_valid & ex_regwrite & rd!=0, select 10. That producer will be in MEM next cycle.
  - Else if the source equals mem_rd, with mem_valid & mem_regwrite & rd!=0, select 01.
  - Else select 00. The register file performs write-before-read, so wb needs no forwarding.
  - Register 0 always yields 00. An unused source (id_use_*=0) always yields 00.
- Registered outputs: fwd_*_sel update on the same edge as ex.
  - They become 00 when ex receives a bubble (stall, flush, or id_valid=0).
- Priority at one edge: hold > flush > stall > normal advance.
  - hold=1: every register, including stall_cnt, keeps its value. stall is still computed combinationally.
  - flush=1: ex gets a bubble, sels=00, and no stall is counted.
- stall_cnt increments by 1 on each edge where stall=1 & hold=0. It saturates at all-ones.
- Latency: one cycle, from ID inputs to sel outputs.
- Reset (rstn=0, asynchronous):
  - All stage valid bits and fields = 0.
  - fwd_a_sel=fwd_b_sel=00.
  - stall_cnt=0.
  - stall reads 0 because ex_valid=0.
  - Reset asserted mid-stall clears everything immediately, with no residual bubble.

Decomposition:
- Shared package or header holds:
  - Select-code constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_AW default.
  - The stage-info record {valid, rd, regwrite, memread}.
- One natural sub-module, fwd_src_cmp: a combinational per-operand comparator returning a 2-bit select. It is instantiated twice (rs, rt).

Test Plan:
- ALU back-to-back, no stall:
  - Stimulus: add r3 in ID, then sub using rs=r3.
  - Required: fwd_a_sel=10 in the sub's EX cycle, stall=0.
- Distance-2 dependence:
  - Stimulus: producer r5, an unrelated instruction, then a consumer with rt=r5.
  - Required: fwd_b_sel=01.
- Distance-3 dependence:
  - Stimulus: same as above with one more unrelated instruction between producer and consumer.
  - Required: fwd_b_sel=00.
- Load-use:
  - Stimulus: lw r4, then add rs=r4.
  - Required: stall=1 for exactly one cycle, EX sels=00 (bubble), then add enters EX with fwd_a_sel=01, and stall_cnt=1.
- Register-0 and unused source:
  - Stimulus: producer writes r0; a consumer reads r0. Separately, a consumer has id_use_rt=0 with rt matching ex_rd.
  - Required: both sels=00, stall=0.
- Flush, hold and reset:
  - flush asserted during load-use condition: stall=0, sels=00, and stall_cnt unchanged.
  - hold=1 for 3 cycles: sels and stall_cnt frozen.
  - rstn pulled low asynchronously mid-stall: outputs go to 00/0/0 before the next edge.
